// File: rtl/prng_word_packer_if.sv
// Interface for prng_word_packer.
// Groups the sample inputs (en, lfsr_up, lfsr_down), the consumer handshake
// (out_ready, out_valid, out_data) and the status outputs (fill, drop_cnt,
// stuck).
//   master : the driving side (LFSR source / consumer / testbench)
//   slave  : the packer itself
interface prng_word_packer_if #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 4
);
    logic                        en;
    logic [15:0]                 lfsr_up;
    logic [7:0]                  lfsr_down;
    logic                        out_ready;
    logic                        out_valid;
    logic [8*WORD_BYTES-1:0]     out_data;
    logic [$clog2(DEPTH):0]      fill;
    logic [7:0]                  drop_cnt;
    logic                        stuck;

    modport master (
        output en, lfsr_up, lfsr_down, out_ready,
        input  out_valid, out_data, fill, drop_cnt, stuck
    );

    modport slave (
        input  en, lfsr_up, lfsr_down, out_ready,
        output out_valid, out_data, fill, drop_cnt, stuck
    );
endinterface

// File: rtl/prng_word_packer.sv
// prng_word_packer
// Combines the 16-bit / 8-bit LFSR outputs into one byte per enabled cycle,
// runs a repetition-count health test on that byte, packs bytes LSB-first
// into WORD_BYTES-wide words and buffers the words in a DEPTH-entry FIFO.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : prng_word_packer_if.slave
//          en/lfsr_up/lfsr_down  sample inputs
//          out_valid/out_ready/out_data  word delivery handshake
//          fill      words held in the FIFO
//          drop_cnt  saturating count of words lost to a full FIFO
//          stuck     sticky health-test failure
module prng_word_packer #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 4,
    parameter int REP_LIMIT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    prng_word_packer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef logic [WORD_BYTES-1:0][7:0] word_t;

    logic [7:0]    b;
    logic [7:0]    prev_b;
    logic [7:0]    rep_cnt;
    logic [7:0]    rep_next;
    logic [IW-1:0] idx;
    word_t         pack_reg;
    word_t         word_next;
    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill_q;
    logic [7:0]    drop_q;
    logic          stuck_q;
    logic          sample;
    logic          trip;
    logic          push;
    logic          pop;
    logic          accept;

    assign b      = bus.lfsr_up[7:0] ^ bus.lfsr_down;
    assign sample = bus.en && !stuck_q;

    // rep_cnt == 0 only before the first sample after reset, so it doubles
    // as the "no previous byte yet" marker.
    assign rep_next = (rep_cnt != 8'd0 && b == prev_b) ? rep_cnt + 8'd1 : 8'd1;
    assign trip     = sample && (rep_next == 8'(REP_LIMIT));
    assign push     = sample && !trip && (idx == IW'(WORD_BYTES - 1));
    assign pop      = bus.out_valid && bus.out_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign accept   = push && ((fill_q != (AW+1)'(DEPTH)) || pop);

    // Current pack register with the incoming byte merged in; this is both
    // the next pack state and the word pushed when it completes.
    always_comb begin
        word_next      = pack_reg;
        word_next[idx] = b;
    end

    // Health test and packer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_b   <= '0;
            rep_cnt  <= '0;
            idx      <= '0;
            pack_reg <= '0;
            stuck_q  <= 1'b0;
        end else if (sample) begin
            prev_b  <= b;
            rep_cnt <= rep_next;
            if (trip) begin
                stuck_q <= 1'b1;
                idx     <= '0;      // partial word discarded
            end else begin
                pack_reg <= word_next;
                idx      <= push ? '0 : idx + 1'b1;
            end
        end
    end

    // Word FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            drop_q <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= word_next;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
            if (push && !accept && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.out_valid = (fill_q != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign bus.fill      = fill_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.stuck     = stuck_q;
endmodule

// File: doc/prng_word_packer.md
Name: prng_word_packer

Overview:
- Downstream consumer of the 16-bit and 8-bit LFSR pair.
- Each enabled cycle it combines the LFSR outputs into one byte and runs a repetition-count health test on that byte.
- It packs bytes into WORD_BYTES-wide words and buffers the words in a small FIFO.
- Words are delivered to the consumer over a valid/ready interface.

Parameters:
- WORD_BYTES, 4, bytes per output word (1..8).
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.
- REP_LIMIT, 8, count of consecutive identical bytes that declares the source stuck (2..255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; one byte is taken per cycle while high.
- lfsr_up  in  16  output of the 16-bit LFSR.
- lfsr_down  in  8  output of the 8-bit LFSR.
- out_ready  in  1  consumer ready.
- out_valid  out  1  FIFO non-empty.
- out_data  out  8*WORD_BYTES  FIFO head word.
- fill  out  clog2(DEPTH)+1  number of words held in the FIFO.
- drop_cnt  out  8  count of words dropped because the FIFO was full; saturates.
- stuck  out  1  sticky health-test failure flag.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, fill=0, drop_cnt=0, stuck=0. Pack register, byte index, rep counter, previous byte and FIFO pointers all clear. Reset mid-word discards the partial word and all FIFO contents.
- Sample byte: b = lfsr_up[7:0] ^ lfsr_down, taken at a posedge where en=1. No sample is taken when en=0, and all packer and health state holds.
- Health test:
  - rep_cnt is 8 bits. The first sample after reset sets rep_cnt=1.
  - Each later sample: if b equals the previous sample, rep_cnt+1; otherwise rep_cnt=1. The previous sample register is always updated.
  - When the updated rep_cnt equals REP_LIMIT, stuck is set at that edge and stays 1 until rst. The byte that trips the test is not packed.
  - Once stuck=1: no further bytes are packed, the partial word is discarded (index=0), and the FIFO keeps draining normally.
- Packing:
  - Byte index i runs 0..WORD_BYTES-1. Byte i is stored at bits [8i+7:8i], so the first byte lands in the LSBs.
  - On the sample with i=WORD_BYTES-1, the completed word (including that byte) is presented for push at the same edge and i wraps to 0.
- FIFO:
  - A push at edge k is visible on out_data/out_valid after edge k. Latency from the last byte's sampling edge to out_valid is 0 cycles beyond that edge.
  - Pop happens when out_valid && out_ready at a posedge.
  - Push is accepted if fill<DEPTH, or if fill==DEPTH and a pop occurs at the same edge.
  - Otherwise the word is dropped and drop_cnt increments, holding at 255.
  - Simultaneous push and pop: fill is unchanged and ordering is preserved.
  - Pop when empty is impossible because out_valid=0.
  - out_data is the head word whenever out_valid=1; its value is don't-care, but stable, when empty.
- out_valid and fill are registered, not combinational from out_ready.

Test Plan:
- Reset values: assert rst mid-operation with 2 words buffered -> out_valid=0, fill=0, drop_cnt=0, stuck=0 immediately, without waiting for a clk edge.
- Packing order: samples b=0x11,0x22,0x33,0x44 on consecutive enabled cycles (lfsr_down=0, lfsr_up[7:0] driven to those values) -> after 4th edge out_valid=1, out_data=0x44332211, fill=1.
- Overflow: out_ready=0, feed 5 words of distinct bytes -> fill=4, drop_cnt=1. Then out_ready=1 drains the first 4 words in order in 4 cycles, and out_valid=0 afterwards.
- Full with simultaneous pop: fill=4, out_ready=1, and a 5th word completes on the same edge -> word accepted, fill stays 4, drop_cnt=0.
- Health test: 7 consecutive 0xA5 samples -> stuck=0. The 8th consecutive 0xA5 -> stuck=1 after that edge, and subsequent random bytes are not packed (fill frozen apart from pops).
- en gaps: bytes 0x01,0x02, en low 3 cycles, then 0x03,0x04 -> single word 0x04030201, and rep_cnt is not disturbed by the gap.
